// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - shared op codes, ACC mode codes and sequencer states (ACC_SEQ_MUL_EN gates MUL4)
package acc_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHR8 = 3'b010,
        OP_SHL8 = 3'b011,
        OP_MUL4 = 3'b100,
        OP_READ = 3'b101,
        OP_CLRH = 3'b110,
        OP_NOP7 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ACC_HOLD = 2'b00,
        ACC_SHR  = 2'b01,
        ACC_SHL  = 2'b10,
        ACC_LOAD = 2'b11
    } acc_mode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_H,
        S_LOAD_L,
        S_CLR_H,
        S_SHIFT,
        S_MUL_ADD,
        S_MUL_SHIFT,
        S_READ,
        S_DONE
    } state_e;

    // Ops without an action phase (and MUL4 when not built) fall straight to DONE.
    function automatic state_e first_state(input op_e op);
        case (op)
            OP_LOAD:          first_state = S_LOAD_H;
            OP_SHR8, OP_SHL8: first_state = S_SHIFT;
`ifdef ACC_SEQ_MUL_EN
            OP_MUL4:          first_state = S_MUL_ADD;
`endif
            OP_READ:          first_state = S_READ;
            OP_CLRH:          first_state = S_CLR_H;
            default:          first_state = S_DONE;
        endcase
    endfunction

endpackage

// File: rtl/acc_seq_if.sv
// rtl/acc_seq_if.sv - request/status handshake and ACC control bundle of the sequencer
interface acc_seq_if;
    logic       start;
    logic [2:0] op;
    logic       acc_low_lsb;
    logic       alu_carry;
    logic       shift_fill;
    logic [1:0] acc_high_select;
    logic [1:0] acc_low_select;
    logic       acc_in_select;
    logic       fill_value;
    logic       acc_high_reset_p;
    logic       rd_en;
    logic       busy;
    logic       done;

    modport slave (
        input  start, op, acc_low_lsb, alu_carry, shift_fill,
        output acc_high_select, acc_low_select, acc_in_select, fill_value,
               acc_high_reset_p, rd_en, busy, done
    );

    modport master (
        output start, op, acc_low_lsb, alu_carry, shift_fill,
        input  acc_high_select, acc_low_select, acc_in_select, fill_value,
               acc_high_reset_p, rd_en, busy, done
    );
endinterface

// File: rtl/acc_seq.sv
// rtl/acc_seq.sv - accumulator control sequencer; MUL4 shift-and-add built only with ACC_SEQ_MUL_EN
module acc_seq
    import acc_seq_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    acc_seq_if.slave  ctl
);

    state_e r_state;
    state_e w_next_state;
    op_e    r_op;

`ifdef ACC_SEQ_MUL_EN
    logic [1:0] r_cnt;
    logic       r_carry;
`else
    logic w_unused_mul;
    assign w_unused_mul = &{1'b0, ctl.acc_low_lsb, ctl.alu_carry};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
`ifdef ACC_SEQ_MUL_EN
            r_cnt   <= 2'd0;
            r_carry <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && ctl.start) begin
                r_op <= op_e'(ctl.op);
            end
`ifdef ACC_SEQ_MUL_EN
            // Carry only survives when the add actually happened this iteration.
            if (r_state == S_MUL_ADD) begin
                r_carry <= ctl.acc_low_lsb ? ctl.alu_carry : 1'b0;
            end
            if (r_state == S_MUL_SHIFT) begin
                r_cnt <= r_cnt + 2'd1;
            end
`endif
        end
    end

    always_comb begin
        w_next_state         = r_state;
        ctl.acc_high_select  = ACC_HOLD;
        ctl.acc_low_select   = ACC_HOLD;
        ctl.acc_in_select    = 1'b0;
        ctl.fill_value       = 1'b0;
        ctl.acc_high_reset_p = 1'b0;
        ctl.rd_en            = 1'b0;
        ctl.done             = 1'b0;
        ctl.busy             = (r_state != S_IDLE) && (r_state != S_DONE);

        case (r_state)
            S_IDLE: begin
                if (ctl.start) begin
                    w_next_state = first_state(op_e'(ctl.op));
                end
            end
            S_LOAD_H: begin
                ctl.acc_high_select = ACC_LOAD;
                ctl.acc_in_select   = 1'b1;
                w_next_state        = S_LOAD_L;
            end
            S_LOAD_L: begin
                ctl.acc_low_select = ACC_LOAD;
                w_next_state       = S_CLR_H;
            end
            S_CLR_H: begin
                ctl.acc_high_reset_p = 1'b1;
                w_next_state         = S_DONE;
            end
            S_SHIFT: begin
                ctl.acc_high_select = (r_op == OP_SHL8) ? ACC_SHL : ACC_SHR;
                ctl.acc_low_select  = (r_op == OP_SHL8) ? ACC_SHL : ACC_SHR;
                ctl.fill_value      = ctl.shift_fill;
                w_next_state        = S_DONE;
            end
            S_READ: begin
                ctl.rd_en    = 1'b1;
                w_next_state = S_DONE;
            end
`ifdef ACC_SEQ_MUL_EN
            S_MUL_ADD: begin
                if (ctl.acc_low_lsb) begin
                    ctl.acc_high_select = ACC_LOAD;
                    ctl.acc_in_select   = 1'b0;
                end
                w_next_state = S_MUL_SHIFT;
            end
            S_MUL_SHIFT: begin
                ctl.acc_high_select = ACC_SHR;
                ctl.acc_low_select  = ACC_SHR;
                ctl.fill_value      = r_carry;
                w_next_state        = (r_cnt == 2'd3) ? S_DONE : S_MUL_ADD;
            end
`endif
            S_DONE: begin
                ctl.done     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_acc_seq.sv
// tb/tb_acc_seq.sv - scoreboard bench for acc_seq with a nibble ACC and fixed-operand ALU
module tb_acc_seq;

    typedef struct {
        logic [7:0] acc;
        int         busy_n;
        int         rd_n;
        int         act_n;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    acc_seq_if u_if();

    acc_seq u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ctl     (u_if.slave)
    );

    // ACC model: 8-bit {acc_h, acc_l}, ALU adds constant operand to acc_h
    logic [3:0] acc_h = 4'h0;
    logic [3:0] acc_l = 4'h0;
    logic [3:0] bus_drv = 4'h0;
    localparam logic [3:0] OPB = 4'hD;
    wire  [4:0] w_sum = {1'b0, acc_h} + {1'b0, OPB};
    wire  [3:0] w_bus = u_if.rd_en ? acc_l : bus_drv;

    assign u_if.alu_carry   = w_sum[4];
    assign u_if.acc_low_lsb = acc_l[0];

    always @(posedge clk) begin
        if (u_if.acc_high_reset_p) acc_h <= 4'h0;
        else case (u_if.acc_high_select)
            2'b01: acc_h <= {u_if.fill_value, acc_h[3:1]};
            2'b10: acc_h <= {acc_h[2:0], (u_if.acc_low_select == 2'b10) ? acc_l[3] : u_if.fill_value};
            2'b11: acc_h <= u_if.acc_in_select ? w_bus : w_sum[3:0];
            default: ;
        endcase
        case (u_if.acc_low_select)
            2'b01: acc_l <= {(u_if.acc_high_select == 2'b01) ? acc_h[0] : u_if.fill_value, acc_l[3:1]};
            2'b10: acc_l <= {acc_l[2:0], u_if.fill_value};
            2'b11: acc_l <= w_bus;
            default: ;
        endcase
    end

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int busy_n = 0, rd_n = 0, act_n = 0;
    logic prev_done = 1'b0;

    wire ctl_active = |{u_if.acc_high_select, u_if.acc_low_select, u_if.acc_in_select,
                        u_if.fill_value, u_if.acc_high_reset_p, u_if.rd_en};
    wire [9:0] w_outs = {u_if.busy, u_if.done, u_if.acc_high_select, u_if.acc_low_select,
                         u_if.acc_in_select, u_if.fill_value, u_if.acc_high_reset_p, u_if.rd_en};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: counts activity between done pulses and checks each pulse against the queue
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_n = 0; rd_n = 0; act_n = 0; prev_done = 1'b0;
        end else begin
            if (u_if.busy) busy_n++;
            if (u_if.rd_en) rd_n++;
            if (ctl_active) act_n++;
            if (u_if.done) begin
                chk("done_single", int'(prev_done), 0);
                chk("busy_in_done", int'(u_if.busy), 0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_acc"}, int'({acc_h, acc_l}), int'(e.acc));
                    chk({e.name, "_busy_cycles"}, busy_n, e.busy_n);
                    chk({e.name, "_rd_cycles"}, rd_n, e.rd_n);
                    chk({e.name, "_active_cycles"}, act_n, e.act_n);
                end
                busy_n = 0; rd_n = 0; act_n = 0;
            end
            prev_done = u_if.done;
        end
    end

    function automatic exp_t mk(input logic [7:0] acc, input int b, input int r, input int a, input string n);
        exp_t e;
        e.acc = acc; e.busy_n = b; e.rd_n = r; e.act_n = a; e.name = n;
        return e;
    endfunction

    task automatic set_acc(input logic [7:0] v);
        @(negedge clk);
        acc_h = v[7:4];
        acc_l = v[3:0];
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] op, input logic fill, input exp_t e);
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op = op;
        u_if.shift_fill = fill;
        q.push_back(e);
        @(negedge clk);
        u_if.start = 1'b0;
        drain();
    endtask

    // start held high: the first op runs alone, the next is taken in the IDLE after DONE
    task automatic held_start(input logic [2:0] op1, input exp_t e1, input exp_t e2);
        int n;
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op = op1;
        q.push_back(e1);
        q.push_back(e2);
        @(negedge clk);
        u_if.op = 3'b011;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!u_if.done && n < 50);
        if (!u_if.done) chk("held_done_timeout", 0, 1);
        u_if.op = 3'b101;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b0;
        drain();
    endtask

    initial begin
        u_if.start = 1'b0;
        u_if.op = 3'b000;
        u_if.shift_fill = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'(w_outs), 0);
        reset_n = 1'b1;

        bus_drv = 4'hB;
        run_op(3'b001, 1'b0, mk(8'h0B, 3, 0, 3, "load"));
        set_acc(8'hA5);
        run_op(3'b010, 1'b1, mk(8'hD2, 1, 0, 1, "shr8"));
        run_op(3'b011, 1'b0, mk(8'hA4, 1, 0, 1, "shl8"));
        run_op(3'b101, 1'b0, mk(8'hA4, 1, 1, 1, "read"));
        run_op(3'b110, 1'b0, mk(8'h04, 1, 0, 1, "clrh"));
        run_op(3'b000, 1'b0, mk(8'h04, 0, 0, 0, "nop0"));
        run_op(3'b111, 1'b0, mk(8'h04, 0, 0, 0, "nop7"));

        set_acc(8'h0B);
`ifdef ACC_SEQ_MUL_EN
        run_op(3'b100, 1'b0, mk(8'h8F, 8, 0, 7, "mul4"));
        set_acc(8'h0B);
        held_start(3'b100, mk(8'h8F, 8, 0, 7, "held_mul4"), mk(8'h8F, 1, 1, 1, "held_read"));

        // Reset lands in the third MUL_ADD cycle
        set_acc(8'h0B);
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.op = 3'b100;
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mul_iter3_busy", int'(u_if.busy), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", int'(w_outs), 0);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_queue_empty", q.size(), 0);
        set_acc(8'h0B);
        run_op(3'b100, 1'b0, mk(8'h8F, 8, 0, 7, "mul4_after_abort"));
`else
        run_op(3'b100, 1'b0, mk(8'h0B, 0, 0, 0, "mul4_as_nop"));
        bus_drv = 4'h3;
        held_start(3'b001, mk(8'h03, 3, 0, 3, "held_load"), mk(8'h03, 1, 1, 1, "held_read"));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
